// File: rtl/arp_envelope_gen.sv
// Four-voice ADSR envelope generator fed by the arpeggiator gates.
// A shared prescaler paces the envelope ticks; each voice runs its own FSM.

module arp_env_voice #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             gate_i,
    input  logic [WIDTH-1:0] attack_step_i,
    input  logic [WIDTH-1:0] decay_step_i,
    input  logic [WIDTH-1:0] sustain_level_i,
    input  logic [WIDTH-1:0] release_step_i,
    output logic [WIDTH-1:0] env_o,
    output logic             active_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE
    } state_e;

    localparam logic [WIDTH-1:0] MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] env_q, env_d;
    logic             active_q, active_d;

    // One extra bit catches overflow on add and borrow on subtract.
    logic [WIDTH:0] att_sum, dec_diff, rel_diff;
    logic           att_sat, dec_hit, rel_zero;

    assign att_sum  = {1'b0, env_q} + {1'b0, attack_step_i};
    assign dec_diff = {1'b0, env_q} - {1'b0, decay_step_i};
    assign rel_diff = {1'b0, env_q} - {1'b0, release_step_i};

    assign att_sat  = (attack_step_i == '0) || att_sum[WIDTH] || (att_sum[WIDTH-1:0] == MAX);
    assign dec_hit  = (decay_step_i == '0) || dec_diff[WIDTH]
                      || (dec_diff[WIDTH-1:0] <= sustain_level_i);
    assign rel_zero = (release_step_i == '0) || rel_diff[WIDTH] || (rel_diff[WIDTH-1:0] == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            env_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (gate_i) state_d = S_ATTACK;
            S_ATTACK:  if (!gate_i) state_d = S_RELEASE;
                       else if (tick_i && att_sat) state_d = S_DECAY;
            S_DECAY:   if (!gate_i) state_d = S_RELEASE;
                       else if (tick_i && dec_hit) state_d = S_SUSTAIN;
            S_SUSTAIN: if (!gate_i) state_d = S_RELEASE;
            S_RELEASE: if (gate_i) state_d = S_ATTACK;
                       else if (tick_i && rel_zero) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // A gate-driven transition freezes env for that cycle.
    always_comb begin
        env_d = env_q;
        unique case (state_q)
            S_IDLE:    env_d = '0;
            S_ATTACK:  if (gate_i && tick_i) env_d = att_sat ? MAX : att_sum[WIDTH-1:0];
            S_DECAY:   if (gate_i && tick_i) env_d = dec_hit ? sustain_level_i : dec_diff[WIDTH-1:0];
            S_SUSTAIN: if (gate_i) env_d = sustain_level_i;
            S_RELEASE: if (!gate_i && tick_i) env_d = rel_zero ? '0 : rel_diff[WIDTH-1:0];
            default:   env_d = '0;
        endcase
        active_d = (state_d != S_IDLE);
    end

    assign env_o    = env_q;
    assign active_o = active_q;
endmodule

module arp_envelope_gen #(
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 256
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             gate0,
    input  logic             gate1,
    input  logic             gate2,
    input  logic             gate3,
    input  logic [WIDTH-1:0] attack_step,
    input  logic [WIDTH-1:0] decay_step,
    input  logic [WIDTH-1:0] sustain_level,
    input  logic [WIDTH-1:0] release_step,
    output logic [WIDTH-1:0] env0,
    output logic [WIDTH-1:0] env1,
    output logic [WIDTH-1:0] env2,
    output logic [WIDTH-1:0] env3,
    output logic             active0,
    output logic             active1,
    output logic             active2,
    output logic             active3
);
    localparam int NUM_VOICES = 4;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count_q, count_d;
    logic          tick;

    assign tick    = (count_q == CW'(TICK_DIV - 1));
    assign count_d = tick ? '0 : count_q + CW'(1);

    always_ff @(posedge CLK) begin
        if (RESET) count_q <= '0;
        else       count_q <= count_d;
    end

    logic [NUM_VOICES-1:0]            gate_w, active_w;
    logic [NUM_VOICES-1:0][WIDTH-1:0] env_w;

    assign gate_w = {gate3, gate2, gate1, gate0};

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        arp_env_voice #(.WIDTH(WIDTH)) u_voice (
            .clk_i          (CLK),
            .rst_i          (RESET),
            .tick_i         (tick),
            .gate_i         (gate_w[v]),
            .attack_step_i  (attack_step),
            .decay_step_i   (decay_step),
            .sustain_level_i(sustain_level),
            .release_step_i (release_step),
            .env_o          (env_w[v]),
            .active_o       (active_w[v])
        );
    end

    assign env0    = env_w[0];
    assign env1    = env_w[1];
    assign env2    = env_w[2];
    assign env3    = env_w[3];
    assign active0 = active_w[0];
    assign active1 = active_w[1];
    assign active2 = active_w[2];
    assign active3 = active_w[3];
endmodule

// File: doc/arp_envelope_gen.md
Name: arp_envelope_gen

Overview:
- Four-voice ADSR (attack, decay, sustain, release) envelope generator. It sits directly downstream of the arpeggiator.
- Consumes the arpeggiator's four key-on gates (out0..out3) and produces one amplitude envelope per voice. The oscillator/mixer stage multiplies each voice by its envelope.
- All four voices share the same rate and sustain settings. Envelope updates are paced by an internal tick prescaler so that envelope times are independent of the system clock.

Parameters:
- WIDTH, 16, envelope amplitude width. Full scale is MAX = 2^WIDTH-1.
- TICK_DIV, 256, number of CLK cycles per envelope update tick. Must be ≥1; TICK_DIV=1 means a tick every cycle.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- gate0..gate3  in  1 each  key-on gates; connect to arpeggiator out0..out3
- attack_step  in  WIDTH  amount added to env per tick in Attack; 0 = jump to MAX immediately
- decay_step  in  WIDTH  amount subtracted per tick in Decay; 0 = jump to sustain_level immediately
- sustain_level  in  WIDTH  level held in Sustain
- release_step  in  WIDTH  amount subtracted per tick in Release; 0 = jump to 0 immediately
- env0..env3  out  WIDTH each  registered envelope amplitude per voice
- active0..active3  out  1 each  registered; 1 when the voice state is not Idle

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET). Every register changes only on posedge CLK.
- RESET=1:
  - All voices go to Idle; env0..3=0; active0..3=0; prescaler=0.
  - Reset mid-operation aborts every envelope with no release phase.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 during the cycle where count==TICK_DIV-1.
  - Free-running; not affected by the gates.
- Per-voice state machine (states Idle, Attack, Decay, Sustain, Release). The gate is sampled every cycle and is level-sensitive.
  - Idle: env=0. gate=1 → Attack.
  - Attack: gate=0 → Release. On tick: env=min(env+attack_step, MAX); if the result is MAX → Decay.
  - Decay: gate=0 → Release. On tick: if env-decay_step ≤ sustain_level, or decay_step=0, then env=sustain_level and state → Sustain; else env=env-decay_step.
  - Sustain: gate=0 → Release. env follows sustain_level every cycle, with one cycle of register latency; no tick needed.
  - Release: gate=1 → Attack, a retrigger that starts from the current env (no drop to 0). On tick: env=max(env-release_step, 0); if the result is 0 → Idle.
- Gate-driven transitions take priority over the tick. In a cycle where a gate causes a state change, env holds its value and no tick update is applied that cycle.
- Arithmetic:
  - Add and subtract use a WIDTH+1-bit intermediate and saturate at MAX and 0. No wrap-around.
  - attack_step, decay_step and release_step are sampled on the tick cycle, so they may change at any time.
- Sustain edge cases:
  - sustain_level=MAX: Decay goes to Sustain on its first tick.
  - sustain_level=0: the voice stays in Sustain at 0 until the gate falls, then Release goes to Idle on the next tick.
- active output:
  - activeN is a registered copy of (next state ≠ Idle), so it asserts in the same cycle that the state leaves Idle.
  - Simultaneous events across voices are fully independent.
- Gate held high through reset: the voice goes Idle→Attack on the first cycle after RESET deasserts.

Test Plan:
- Attack ramp (TICK_DIV=1, attack_step=0x4000, decay_step=0x1000, sustain_level=0xE000, release_step=0x2000); gate0 rises at cycle 0 → active0=1 at cycle 1; env0 = 0x4000, 0x8000, 0xC000, then 0xFFFF (saturated), then 0xEFFF, then 0xE000 (Sustain); env1..3 stay 0.
- Release to Idle: from the previous sustain, gate0 falls → env0 steps down by 0x2000 per tick (0xC000 … 0x2000, 0x0000) → Idle; active0=0 on the cycle env0 reaches 0.
- Retrigger: gate0 re-rises while in Release at env0=0x6000 → env0 holds one cycle, then rises 0xA000, 0xE000, 0xFFFF; env0 never returns to 0.
- Prescaler (TICK_DIV=4, attack_step=0x1000): env0 changes exactly every 4th cycle → 0x1000, 0x2000, …; sustain_level changed from 0xE000 to 0x8000 during Sustain → env0=0x8000 one cycle later.
- Zero steps: attack_step=0 → env=0xFFFF on the first tick; release_step=0 → env=0 and Idle on the first tick after the gate falls.
- Reset and concurrency: all four gates high mid-Decay, RESET pulsed for 1 cycle → all env=0 and active=0 the next cycle, then all four restart Attack in lockstep because the gates are still high.
